// File: rtl/cic_decim_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cic_decim_core                                                  |
// | Purpose  : N-stage CIC decimator for a 1-bit modulator stream. ORDER       |
// |            integrators run on strobed input samples. Decimation is by      |
// |            R = 2^k_act, with k_act taken from the clamped osr_sel. ORDER   |
// |            combs follow, then a variable right shift and saturation to     |
// |            OUT_W bits. The result goes to a valid/ready holding register   |
// |            with a sticky overrun flag.                                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   clock                                                    |
// |   rst_n      in   synchronous active-low reset                             |
// |   osr_sel    in   log2 decimation ratio, clamped to [LOG2_R_MIN,LOG2_R_MAX]|
// |   in_valid   in   data_in carries a new modulator sample                   |
// |   data_in    in   modulator bit (0/1)                                      |
// |   out_data   out  decimated, scaled, saturated sample                      |
// |   out_valid  out  out_data holds an unconsumed sample                       |
// |   out_ready  in   consumer takes out_data when out_valid && out_ready       |
// |   settling   out  filter restarted; early results are being discarded      |
// |   overrun    out  sticky: an unconsumed sample was overwritten             |
// |   ovr_clr    in   clears overrun (a coincident set wins)                    |
// +----------------------------------------------------------------------------+
module cic_decim_core #(
  parameter int ORDER      = 3,
  parameter int LOG2_R_MAX = 9,
  parameter int LOG2_R_MIN = 4,
  parameter int OUT_W      = 12
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [$clog2(LOG2_R_MAX+1)-1:0] osr_sel,
  input  logic                            in_valid,
  input  logic                            data_in,
  output logic [OUT_W-1:0]                out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            settling,
  output logic                            overrun,
  input  logic                            ovr_clr
);

  localparam int SEL_W = $clog2(LOG2_R_MAX + 1);
  // Wide enough to hold the full-scale response 2^(ORDER*LOG2_R_MAX) exactly.
  localparam int W     = ORDER * LOG2_R_MAX + 1;
  localparam int CNT_W = LOG2_R_MAX;
  localparam int SH_W  = $clog2(W + 1);
  localparam int SET_W = $clog2(ORDER + 1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // --------------------------------------------------------------------------
  generate
    if (ORDER < 1 || ORDER > 5) begin : g_chk_order
      $error("cic_decim_core: ORDER must be within 1..5");
    end
    if (LOG2_R_MIN < 1 || LOG2_R_MIN > LOG2_R_MAX) begin : g_chk_range
      $error("cic_decim_core: need 1 <= LOG2_R_MIN <= LOG2_R_MAX");
    end
    if (ORDER * LOG2_R_MIN < OUT_W) begin : g_chk_outw
      $error("cic_decim_core: ORDER*LOG2_R_MIN must be >= OUT_W");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [SEL_W-1:0] k_act;
  logic [SEL_W-1:0] osr_clamped;
  logic             restart;

  logic [CNT_W-1:0] smp_cnt;
  logic [CNT_W-1:0] cnt_last;
  logic             strobe;

  logic [W-1:0]     integ     [ORDER];
  logic [W-1:0]     integ_nxt [ORDER];
  logic [W-1:0]     comb_dly  [ORDER];
  logic [W-1:0]     comb_x    [ORDER+1];

  logic             strobe_d;
  logic             comb_vld;
  logic [W-1:0]     comb_out;

  logic [SH_W-1:0]  shift_amt;
  logic [W-1:0]     shifted;
  logic [OUT_W-1:0] sat_val;
  logic             scl_vld;
  logic [OUT_W-1:0] scl_data;

  logic [SET_W-1:0] settle_cnt;
  logic             settle_last;
  logic             deliver;

  // --------------------------------------------------------------------------
  // Ratio selection and restart detection
  // --------------------------------------------------------------------------
  always_comb begin
    osr_clamped = osr_sel;
    if (osr_sel < SEL_W'(LOG2_R_MIN)) begin
      osr_clamped = SEL_W'(LOG2_R_MIN);
    end else if (osr_sel > SEL_W'(LOG2_R_MAX)) begin
      osr_clamped = SEL_W'(LOG2_R_MAX);
    end
  end

  // A ratio change restarts the whole filter on the next edge.
  assign restart = (osr_clamped != k_act);

  // --------------------------------------------------------------------------
  // Sample counter and decimation strobe
  // --------------------------------------------------------------------------
  assign cnt_last = CNT_W'((32'd1 << k_act) - 32'd1);
  assign strobe   = in_valid && (smp_cnt == cnt_last);

  // --------------------------------------------------------------------------
  // Integrators
  // The adders are chained combinationally. The sample accepted on the strobe
  // edge is then already part of the value the combs pick up one cycle later.
  // Wrap-around in W bits is harmless; the combs cancel it.
  // --------------------------------------------------------------------------
  always_comb begin
    integ_nxt[0] = integ[0] + W'(data_in);
    for (int i = 1; i < ORDER; i++) begin
      integ_nxt[i] = integ[i] + integ_nxt[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      for (int i = 0; i < ORDER; i++) begin
        integ[i] <= '0;
      end
      smp_cnt <= '0;
    end else if (in_valid) begin
      for (int i = 0; i < ORDER; i++) begin
        integ[i] <= integ_nxt[i];
      end
      smp_cnt <= strobe ? '0 : smp_cnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Combs (differential delay 1 at the decimated rate)
  // --------------------------------------------------------------------------
  always_comb begin
    comb_x[0] = integ[ORDER-1];
    for (int i = 0; i < ORDER; i++) begin
      comb_x[i+1] = comb_x[i] - comb_dly[i];
    end
  end

  // Pipeline: strobe edge -> comb register -> scale register -> holding reg.
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      strobe_d <= 1'b0;
      comb_vld <= 1'b0;
      comb_out <= '0;
      for (int i = 0; i < ORDER; i++) begin
        comb_dly[i] <= '0;
      end
    end else begin
      strobe_d <= strobe;
      comb_vld <= strobe_d;
      if (strobe_d) begin
        comb_out <= comb_x[ORDER];
        for (int i = 0; i < ORDER; i++) begin
          comb_dly[i] <= comb_x[i];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scaling and saturation
  // Gain is 2^(ORDER*k_act). Dropping ORDER*k_act-OUT_W bits leaves full scale
  // exactly one count above the OUT_W range, so the clamp is only ever needed
  // at that single full-scale value.
  // --------------------------------------------------------------------------
  assign shift_amt = SH_W'(ORDER * int'(k_act) - OUT_W);
  assign shifted   = comb_out >> shift_amt;
  assign sat_val   = (|shifted[W-1:OUT_W]) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      scl_vld  <= 1'b0;
      scl_data <= '0;
    end else begin
      scl_vld <= comb_vld;
      if (comb_vld) begin
        scl_data <= sat_val;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Settling, output holding register and overrun
  // The first ORDER results after a restart still include the ramp from the
  // cleared state, so they are dropped. The (ORDER+1)-th is delivered and
  // clears settling in the same edge.
  // --------------------------------------------------------------------------
  assign settle_last = (settle_cnt == SET_W'(ORDER));
  assign deliver     = scl_vld && !restart && (!settling || settle_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_act      <= osr_clamped;
      settling   <= 1'b1;
      settle_cnt <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // A restart leaves the holding register alone; only the filter restarts.
      if (restart) begin
        k_act      <= osr_clamped;
        settling   <= 1'b1;
        settle_cnt <= '0;
      end else if (scl_vld && settling) begin
        if (settle_last) begin
          settling <= 1'b0;
        end else begin
          settle_cnt <= settle_cnt + SET_W'(1);
        end
      end

      // A new result always wins over a same-cycle transfer; valid stays high.
      if (deliver) begin
        out_data  <= scl_data;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Setting has priority over clearing.
      if (deliver && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cic_decim_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cic_decim_core                                               |
// | Purpose  : Self-checking bench for cic_decim_core. A reference model built  |
// |            from ORDER cascaded length-R moving sums predicts each          |
// |            decimated result and the edge it should appear on. A monitor    |
// |            compares DUT outputs against the queued predictions.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cic_decim_core;

  localparam int ORDER      = 3;
  localparam int LOG2_R_MAX = 9;
  localparam int LOG2_R_MIN = 4;
  localparam int OUT_W      = 12;
  localparam int SEL_W      = 4;
  localparam int LAT        = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [SEL_W-1:0] osr_sel;
  logic             in_valid;
  logic             data_in;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             settling;
  logic             overrun;
  logic             ovr_clr;

  always #5 clk = ~clk;

  cic_decim_core #(
    .ORDER      (ORDER),
    .LOG2_R_MAX (LOG2_R_MAX),
    .LOG2_R_MIN (LOG2_R_MIN),
    .OUT_W      (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .osr_sel   (osr_sel),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .settling  (settling),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc   = 0;

  typedef struct {
    longint due;
    int     val;
  } ent_t;
  ent_t sbq[$];

  // Reference model state
  int     m_k      = LOG2_R_MAX;
  longint m_cnt    = 0;
  int     m_frames = 0;
  longint s1 = 0, s2 = 0, s3 = 0;
  longint q1[$], q2[$], q3[$];
  bit     exp_valid  = 1'b0;
  bit     exp_ovr    = 1'b0;
  bit     exp_settle = 1'b1;
  longint drop_at    = -1;
  bit     alt        = 1'b1;

  function automatic void chk(string nm, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic int clamp(int v);
    if (v < LOG2_R_MIN) return LOG2_R_MIN;
    if (v > LOG2_R_MAX) return LOG2_R_MAX;
    return v;
  endfunction

  function automatic bit pending(longint e);
    foreach (sbq[i]) if (sbq[i].due == e) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_clear_filter();
    s1 = 0; s2 = 0; s3 = 0;
    q1.delete(); q2.delete(); q3.delete();
    m_cnt      = 0;
    m_frames   = 0;
    drop_at    = -1;
    exp_settle = 1'b1;
  endfunction

  // CIC response = ORDER cascaded moving sums of length R, sampled at frame ends.
  function automatic void model_sample(longint x);
    longint r;
    longint old;
    longint v;
    ent_t   e;
    r = longint'(1) << m_k;
    old = 0; if (q1.size() >= r) old = q1.pop_front(); q1.push_back(x);  s1 = s1 + x  - old;
    old = 0; if (q2.size() >= r) old = q2.pop_front(); q2.push_back(s1); s2 = s2 + s1 - old;
    old = 0; if (q3.size() >= r) old = q3.pop_front(); q3.push_back(s2); s3 = s3 + s2 - old;
    m_cnt++;
    if (m_cnt == r) begin
      m_cnt = 0;
      m_frames++;
      if (m_frames > ORDER) begin
        v = s3 >> (ORDER * m_k - OUT_W);
        if (v > (longint'(1) << OUT_W) - 1) v = (longint'(1) << OUT_W) - 1;
        e.due = cyc + LAT;
        e.val = int'(v);
        sbq.push_back(e);
        if (drop_at < 0) drop_at = e.due;
      end
    end
  endfunction

  // Applies the inputs present at clock edge number cyc.
  function automatic void model_edge();
    bit newres;
    int kc;
    kc     = clamp(int'(osr_sel));
    newres = 1'b0;
    if (!rst_n) begin
      sbq.delete();
      m_k = kc;
      model_clear_filter();
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      return;
    end
    if (kc != m_k) begin
      while (sbq.size() > 0 && sbq[$].due >= cyc) void'(sbq.pop_back());
      m_k = kc;
      model_clear_filter();
    end else begin
      newres = pending(cyc);
      if (exp_settle && drop_at == cyc) exp_settle = 1'b0;
      if (in_valid) model_sample(longint'(data_in));
    end
    if (newres && exp_valid && !out_ready) exp_ovr = 1'b1;
    else if (ovr_clr)                      exp_ovr = 1'b0;
    if (newres)                         exp_valid = 1'b1;
    else if (exp_valid && out_ready)    exp_valid = 1'b0;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: flags every cycle, data at its due edge, data on each transfer
  // ---------------------------------------------------------------------------
  initial begin
    ent_t last;
    bit   found;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        chk("out_valid", longint'(out_valid), longint'(exp_valid));
        chk("overrun",   longint'(overrun),   longint'(exp_ovr));
        chk("settling",  longint'(settling),  longint'(exp_settle));
        foreach (sbq[i])
          if (sbq[i].due == cyc) chk("out_data_at_latency", longint'(out_data), longint'(sbq[i].val));
        if (out_valid && out_ready) begin
          found = 1'b0;
          while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            last  = sbq.pop_front();
            found = 1'b1;
          end
          chk("transfer_has_pending", longint'(found), 1);
          if (found) chk("transfer_data", longint'(out_data), longint'(last.val));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  // dmode: 0 zeros, 1 ones, 2 alternating per accepted sample, 3 random
  // vmode: 0 every cycle, 1 toggling, 2 random 3/4
  // rmode: 0 leave out_ready/ovr_clr, 1 randomise them
  task automatic run(int n, int dmode, int vmode, int rmode);
    for (int i = 0; i < n; i++) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = ~in_valid;
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      case (dmode)
        0: data_in = 1'b0;
        1: data_in = 1'b1;
        2: begin
          data_in = alt;
          if (in_valid) alt = ~alt;
        end
        default: data_in = 1'($urandom_range(0, 1));
      endcase
      if (rmode == 1) begin
        out_ready = ($urandom_range(0, 3) != 0);
        ovr_clr   = ($urandom_range(0, 15) == 0);
      end
      step();
    end
  endtask

  initial begin
    int held;
    int stale;
    rst_n     = 1'b0;
    osr_sel   = 4'd9;
    in_valid  = 1'b0;
    data_in   = 1'b0;
    out_ready = 1'b1;
    ovr_clr   = 1'b0;
    step();
    step();
    chk("reset_out_data", longint'(out_data), 0);
    chk("reset_settling", longint'(settling), 1);
    rst_n = 1'b1;

    // Full scale at R=512 saturates to all-ones after three dropped results.
    run(5 * 512 + 8, 1, 0, 0);
    // Alternating input at R=512, then R=32.
    run(5 * 512, 2, 0, 0);
    osr_sel = 4'd5;
    run(8 * 32 + 8, 2, 0, 0);
    // Below-minimum ratio clamps to R=16.
    osr_sel = 4'd2;
    run(8 * 16 + 8, 0, 0, 0);
    // Above-maximum ratio clamps to R=512; in_valid toggling doubles the period.
    osr_sel = 4'd13;
    in_valid = 1'b0;
    run(5 * 1024 + 8, 2, 1, 0);

    // Overrun: stall the consumer, pulse ovr_clr exactly on the overwrite edges.
    osr_sel = 4'd4;
    run(5 * 16 + 8, 3, 0, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 60; i++) begin
      ovr_clr  = pending(cyc + 1);
      in_valid = 1'b1;
      data_in  = 1'($urandom_range(0, 1));
      step();
    end
    chk("overrun_set_wins", longint'(overrun), 1);
    in_valid = 1'b0;
    ovr_clr  = 1'b0;
    while (pending(cyc + 1)) step();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("overrun_cleared", longint'(overrun), 0);

    // Ratio change mid-frame with a pending sample, then reset mid-frame.
    osr_sel = 4'd9;
    run(5 * 512 + 200, 2, 0, 0);
    held = (sbq.size() > 0) ? sbq[$].val : -1;
    chk("pending_before_change", longint'(out_valid), 1);
    osr_sel = 4'd6;
    run(1, 2, 0, 0);
    chk("retained_data", longint'(out_data), longint'(held));
    chk("settling_on_change", longint'(settling), 1);
    out_ready = 1'b1;
    run(6 * 64 + 30, 2, 0, 0);
    rst_n = 1'b0;
    run(1, 2, 0, 0);
    rst_n = 1'b1;
    chk("midreset_out_data", longint'(out_data), 0);
    chk("midreset_out_valid", longint'(out_valid), 0);
    chk("midreset_settling", longint'(settling), 1);

    // Randomised traffic, ratio changes, backpressure and clears.
    for (int seg = 0; seg < 100; seg++) begin
      if ($urandom_range(0, 3) == 0) osr_sel = 4'($urandom_range(2, 7));
      run(int'($urandom_range(50, 400)), 3, 2, 1);
    end

    // Drain and confirm nothing predicted was left undelivered.
    out_ready = 1'b1;
    ovr_clr   = 1'b0;
    in_valid  = 1'b0;
    for (int i = 0; i < 12; i++) step();
    stale = 0;
    foreach (sbq[i]) if (sbq[i].due <= cyc) stale++;
    chk("undelivered_results", longint'(stale), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
